// File: rtl/r_i_controller_if.sv
// Instruction-memory fetch handshake between the R/I-type sequencer and imem.
// The master drives the request and PC; the slave returns the fetched word.
interface r_i_controller_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_valid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/r_i_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for an RV32I R/I-type core.
// EBREAK parks the core in HALT; any unsupported encoding parks it in TRAP.
module r_i_controller #(
  parameter int                     INSTRUCTION = 32,
  parameter logic [INSTRUCTION-1:0] PC_RESET    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  r_i_controller_if.master       imem,
  output logic [INSTRUCTION-1:0] instruction,
  output logic                   alu_src_imm,
  output logic [3:0]             alu_ctrl,
  output logic                   rf_we,
  output logic                   halted,
  output logic                   illegal,
  output logic [31:0]            retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT, S_TRAP
  } state_t;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  F7_ALT = 7'b0100000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t state;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  logic       dec_legal;
  logic       dec_imm;
  logic [3:0] dec_ctrl;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_legal = 1'b0;
    dec_imm   = 1'b0;
    dec_ctrl  = 4'b0000;
    unique case (opcode)
      OP_R: begin
        dec_legal = (f7 == 7'b0) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        dec_ctrl  = {f7[5], f3};
      end
      OP_I: begin
        dec_imm = 1'b1;
        unique case (f3)
          3'b001: begin
            dec_legal = (f7 == 7'b0);
            dec_ctrl  = {1'b0, f3};
          end
          3'b101: begin
            dec_legal = (f7 == 7'b0) || (f7 == F7_ALT);
            dec_ctrl  = {f7[5], 3'b101};
          end
          // Upper immediate bits are data here, never funct bits.
          default: begin
            dec_legal = 1'b1;
            dec_ctrl  = {1'b0, f3};
          end
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: state and all registered outputs use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= PC_RESET;
      instruction    <= '0;
      alu_src_imm    <= 1'b0;
      alu_ctrl       <= 4'b0000;
      rf_we          <= 1'b0;
      halted         <= 1'b0;
      illegal        <= 1'b0;
      retired        <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_FETCH;
            imem.imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_valid) begin
            instruction   <= imem.imem_rdata;
            imem.imem_req <= 1'b0;
            state         <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_legal) begin
            alu_src_imm <= dec_imm;
            alu_ctrl    <= dec_ctrl;
            state       <= S_EXECUTE;
          end else if (instruction == EBREAK) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= S_TRAP;
          end
        end
        S_EXECUTE: begin
          // Writes to x0 are architecturally discarded, so suppress the strobe.
          rf_we <= (rd != 5'd0);
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          imem.imem_addr <= imem.imem_addr + INSTRUCTION'(4);
          retired        <= retired + 32'd1;
          imem.imem_req  <= 1'b1;
          state          <= S_FETCH;
        end
        S_HALT, S_TRAP: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_i_controller.sv
// Self-checking bench for r_i_controller: vector table through a scoreboard queue,
// plus hand-written HALT, TRAP, PC wrap and mid-FETCH reset sequences.
module tb_r_i_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instruction, instruction2;
  logic        alu_src_imm, alu_src_imm2;
  logic [3:0]  alu_ctrl, alu_ctrl2;
  logic        rf_we, rf_we2;
  logic        halted, halted2;
  logic        illegal, illegal2;
  logic [31:0] retired, retired2;

  r_i_controller_if #(.WIDTH(32)) bus ();
  r_i_controller_if #(.WIDTH(32)) bus2 ();

  assign bus2.imem_valid = bus.imem_valid;
  assign bus2.imem_rdata = bus.imem_rdata;

  r_i_controller #(.INSTRUCTION(32), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem(bus),
    .instruction(instruction), .alu_src_imm(alu_src_imm), .alu_ctrl(alu_ctrl),
    .rf_we(rf_we), .halted(halted), .illegal(illegal), .retired(retired)
  );

  // Second core with a wrapping reset PC, fed the same stimulus.
  r_i_controller #(.INSTRUCTION(32), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .imem(bus2),
    .instruction(instruction2), .alu_src_imm(alu_src_imm2), .alu_ctrl(alu_ctrl2),
    .rf_we(rf_we2), .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic        imm;
    logic [3:0]  ctrl;
    logic        we;
    int          cycles;
  } vec_t;

  vec_t        vecs[7];
  vec_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        last_imm;
  logic [3:0]  last_ctrl;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},     {31'b0, bus.imem_req}, 32'd0);
    check({tag, "_addr"},    bus.imem_addr, 32'h0000_0000);
    check({tag, "_addr2"},   bus2.imem_addr, 32'hFFFF_FFFC);
    check({tag, "_ir"},      instruction, 32'd0);
    check({tag, "_ctrl"},    {28'b0, alu_ctrl}, 32'd0);
    check({tag, "_imm"},     {31'b0, alu_src_imm}, 32'd0);
    check({tag, "_we"},      {31'b0, rf_we}, 32'd0);
    check({tag, "_halted"},  {31'b0, halted}, 32'd0);
    check({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
  endtask

  // Pulse start from IDLE; leaves the core in its first FETCH cycle.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_req", {31'b0, bus.imem_req}, 32'd1);
    exp_pc  = 32'd0;
    exp_ret = 32'd0;
  endtask

  // Called in a FETCH cycle; returns in the next FETCH cycle.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc = 0;
    exp_q.push_back(v);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    for (int d = 0; d < v.delay; d++) begin
      step();
      cyc++;
    end
    check("fetch_req_held", {31'b0, bus.imem_req}, 32'd1);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = v.instr;
    step();
    cyc++;
    bus.imem_valid = 1'b0;
    check("ir_latch", instruction, v.instr);
    check("req_drop", {31'b0, bus.imem_req}, 32'd0);
    step();
    cyc++;
    e = exp_q.pop_front();
    check("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, e.imm});
    check("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, e.ctrl});
    step();
    cyc++;
    check("rf_we_wb", {31'b0, rf_we}, {31'b0, e.we});
    check("pc_before_wb", bus.imem_addr, exp_pc);
    step();
    cyc++;
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    last_imm  = e.imm;
    last_ctrl = e.ctrl;
    check("pc_after_wb", bus.imem_addr, exp_pc);
    check("retired", retired, exp_ret);
    check("rf_we_low", {31'b0, rf_we}, 32'd0);
    check("refetch_req", {31'b0, bus.imem_req}, 32'd1);
    check("cycles", cyc, e.cycles);
  endtask

  // Called in a FETCH cycle with an EBREAK or illegal word.
  task automatic run_stop(input logic [31:0] instr, input logic trap);
    logic we_seen = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = instr;
    step();
    bus.imem_valid = 1'b0;
    step();
    check("stop_halted", {31'b0, halted}, 32'd1);
    check("stop_illegal", {31'b0, illegal}, {31'b0, trap});
    check("stop_ctrl_held", {28'b0, alu_ctrl}, {28'b0, last_ctrl});
    check("stop_imm_held", {31'b0, alu_src_imm}, {31'b0, last_imm});
    for (int i = 0; i < 6; i++) begin
      bus.imem_valid = i[0];
      bus.imem_rdata = 32'h0050_0093;
      step();
      we_seen = we_seen | rf_we;
    end
    bus.imem_valid = 1'b0;
    check("stop_no_we", {31'b0, we_seen}, 32'd0);
    check("stop_pc", bus.imem_addr, exp_pc);
    check("stop_retired", retired, exp_ret);
    check("stop_ir", instruction, instr);
    check("stop_req", {31'b0, bus.imem_req}, 32'd0);
    check("stop_still_halted", {31'b0, halted}, 32'd1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    vec_t addi5;
    vecs[0] = '{32'h0050_0093, 0, 1'b1, 4'b0000, 1'b1, 4}; // ADDI x1,x0,5
    vecs[1] = '{32'h4020_81B3, 3, 1'b0, 4'b1000, 1'b1, 7}; // SUB x3,x1,x2
    vecs[2] = '{32'h4032_D293, 1, 1'b1, 4'b1101, 1'b1, 5}; // SRAI x5,x5,3
    vecs[3] = '{32'h0000_0013, 0, 1'b1, 4'b0000, 1'b0, 4}; // ADDI x0,x0,0
    vecs[4] = '{32'hFFF0_E093, 2, 1'b1, 4'b0110, 1'b1, 6}; // ORI x1,x1,-1
    vecs[5] = '{32'h4020_D1B3, 0, 1'b0, 4'b1101, 1'b1, 4}; // SRA x3,x1,x2
    vecs[6] = '{32'h0030_9093, 0, 1'b1, 4'b0001, 1'b1, 4}; // SLLI x1,x1,3
    addi5 = vecs[0];

    rst_n = 1'b0;
    start = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    last_imm  = 1'b0;
    last_ctrl = 4'b0000;
    repeat (2) step();
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Idle must not fetch without start, even with imem_valid high.
    bus.imem_valid = 1'b1;
    step();
    bus.imem_valid = 1'b0;
    check("idle_no_req", {31'b0, bus.imem_req}, 32'd0);
    check("idle_ir", instruction, 32'd0);

    kick();
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) check("wrap_pc", bus2.imem_addr, 32'h0000_0000);
    end

    // Async reset in the middle of a FETCH cycle.
    bus.imem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midfetch");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle_req", {31'b0, bus.imem_req}, 32'd0);

    // Two ADDIs then EBREAK.
    kick();
    run_vec(addi5);
    run_vec(addi5);
    run_stop(32'h0010_0073, 1'b0);
    check("ebreak_retired", retired, 32'd2);
    check("ebreak_pc", bus.imem_addr, 32'd8);

    // ADDI then SLLI with f7=0100000 traps.
    reset_pulse();
    check_reset_outputs("rst2");
    kick();
    run_vec(addi5);
    run_stop(32'h4030_9093, 1'b1);
    check("trap_pc", bus.imem_addr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
